// File: rtl/serial_cmp_pkg.sv
// ============================================================================
// Module : serial_cmp_pkg
// Brief  : FSM state and result encodings for serial_magnitude_comparator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One-hot result vector, bit order {Greater, Equal, Less}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

endpackage : serial_cmp_pkg

`default_nettype wire

// File: rtl/chunk_compare.sv
// ============================================================================
// Module : chunk_compare
// Brief  : Combinational unsigned STEP-bit compare, reports a > b and a == b.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module chunk_compare
  import serial_cmp_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  output logic            gt,
  output logic            eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule : chunk_compare

`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
// ============================================================================
// Module : serial_magnitude_comparator
// Brief  : Multi-cycle MSB-first magnitude compare, STEP bits per cycle, with
//          early exit; optional two's-complement mode under COMPARE_SIGNED_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef COMPARE_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             Greater,
  output logic             Equal,
  output logic             Less
);

  localparam int NCHUNK = WIDTH / STEP;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] C_IDX_TOP = IDXW'(NCHUNK - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic [2:0]       r_res;
  logic [STEP-1:0]  w_ca;
  logic [STEP-1:0]  w_cb;
  logic             w_gt;
  logic             w_eq;
  logic             w_accept;
  logic             w_last;

  // DONE is not busy, so a new request may be taken back-to-back
  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_idx == '0);

`ifdef COMPARE_SIGNED_EN
  localparam logic [STEP-1:0] C_MSB_MASK = STEP'(1) << (STEP - 1);
  logic r_signed;
  logic [STEP-1:0] w_flip;

  // Inverting the sign bit of both operands maps two's complement onto unsigned order
  assign w_flip = (r_signed && (r_idx == C_IDX_TOP)) ? C_MSB_MASK : '0;
  assign w_ca   = r_a[r_idx*STEP +: STEP] ^ w_flip;
  assign w_cb   = r_b[r_idx*STEP +: STEP] ^ w_flip;
`else
  assign w_ca   = r_a[r_idx*STEP +: STEP];
  assign w_cb   = r_b[r_idx*STEP +: STEP];
`endif

  chunk_compare #(
    .STEP (STEP)
  ) u_chunk_compare (
    .a  (w_ca),
    .b  (w_cb),
    .gt (w_gt),
    .eq (w_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_RUN;
      ST_RUN:  if (!w_eq || w_last) w_next = ST_DONE;
      ST_DONE: w_next = w_accept ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_res <= RES_NONE;
`ifdef COMPARE_SIGNED_EN
      r_signed <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_idx <= C_IDX_TOP;
`ifdef COMPARE_SIGNED_EN
      r_signed <= signed_mode;
`endif
    end else if (r_state == ST_RUN) begin
      if (!w_eq) begin
        r_res <= w_gt ? RES_GT : RES_LT;
      end else if (w_last) begin
        r_res <= RES_EQ;
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign Greater = r_res[2];
  assign Equal   = r_res[1];
  assign Less    = r_res[0];

endmodule : serial_magnitude_comparator

`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
// ============================================================================
// Module : tb_serial_magnitude_comparator
// Brief  : Directed plus random self-checking bench against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_magnitude_comparator;

  localparam int W      = 8;
  localparam int S      = 2;
  localparam int NCH    = W / S;
  localparam int C_LIMIT = 2 * NCH + 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         signed_mode = 1'b0;
  logic         busy, done, Greater, Equal, Less;

  int n_total = 0;
  int n_bad   = 0;

  serial_magnitude_comparator #(
    .WIDTH (W),
    .STEP  (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
`ifdef COMPARE_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy),
    .done        (done),
    .Greater     (Greater),
    .Equal       (Equal),
    .Less        (Less)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected {G,E,L} from plain arithmetic; k = chunks scanned until the first difference
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                                output logic [2:0] res, output int k);
    int ia, ib;
    bit found;
    if (sm) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    res = (ia > ib) ? 3'b100 : (ia == ib) ? 3'b010 : 3'b001;
    k = NCH;
    found = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!found && (((int'(a) >> (i * S)) % (1 << S)) != ((int'(b) >> (i * S)) % (1 << S)))) begin
        k = NCH - i;
        found = 1;
      end
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the done cycle
  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm, input bit poke);
    logic [2:0] exp_res;
    int k, n, busy_cnt;
    bit seen;
    bit use_sm;
`ifdef COMPARE_SIGNED_EN
    use_sm = sm;
`else
    use_sm = 1'b0;
`endif
    model(a, b, use_sm, exp_res, k);
    start = 1'b1; A = a; B = b; signed_mode = sm;
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b;
    busy_cnt = 0;
    seen = 0;
    n = 1;
    while (!seen && n <= C_LIMIT) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) busy_cnt++;
        if (poke && n == 1) begin
          start = 1'b1; A = 8'h00; B = 8'hFF;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_latency", n, k + 1);
    chk("busy_cycles", busy_cnt, k);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("result", {Greater, Equal, Less}, exp_res);
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("result_hold", {Greater, Equal, Less}, exp_res);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int dcount;

    #2;
    chk("rst_async_outs", {busy, done, Greater, Equal, Less}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {busy, done, Greater, Equal, Less}, 5'b0);

    do_cmp(8'h80, 8'h00, 1'b0, 1'b0);
    do_cmp(8'h5A, 8'h5A, 1'b0, 1'b0);
    do_cmp(8'h01, 8'h02, 1'b0, 1'b0);
    do_cmp(8'hC3, 8'hC1, 1'b0, 1'b1);
    do_cmp(8'h01, 8'h02, 1'b0, 1'b1);

    // Abort during the second RUN cycle
    start = 1'b1; A = 8'h33; B = 8'h33;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_outs", {busy, done, Greater, Equal, Less}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    do_cmp(8'h33, 8'h32, 1'b0, 1'b0);

`ifdef COMPARE_SIGNED_EN
    do_cmp(8'hFF, 8'h01, 1'b1, 1'b0);
    do_cmp(8'hFF, 8'h01, 1'b0, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ W'($urandom_range(1, 3));
        2: rb = ra ^ W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      do_cmp(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_serial_magnitude_comparator

`default_nettype wire
